// File: rtl/fft_tw_pkg.sv
// Shared constants for the 4096-point radix-4 FFT twiddle path.
// Used by twiddle_addr_gen (address sequencing) and rom_twiddle (storage).
package fft_tw_pkg;

    localparam int NUM_STAGES = 6;
    localparam int ADDR_W     = 11;

    // Encodings are fixed so existing waveform decoders keep working
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tw_state_e;

    // Per-stage ROM window: first word, number of distinct twiddles, and how
    // many times that window is replayed so every stage issues 128 beats
    localparam logic [7:0] STAGE_BASE  [NUM_STAGES] = '{8'd0,   8'd1,   8'd2,  8'd4,  8'd12, 8'd44};
    localparam logic [7:0] STAGE_WORDS [NUM_STAGES] = '{8'd1,   8'd1,   8'd2,  8'd8,  8'd32, 8'd128};
    localparam logic [7:0] STAGE_REPS  [NUM_STAGES] = '{8'd128, 8'd128, 8'd64, 8'd16, 8'd4,  8'd1};

    // ROM word address of twiddle w within stage s
    function automatic logic [7:0] stage_addr(input logic [2:0] s, input logic [6:0] w);
        return STAGE_BASE[s] + {1'b0, w};
    endfunction

    // True for the final beat of a stage: last word of the last replay
    function automatic logic is_last_beat(input logic [2:0] s, input logic [6:0] w,
                                          input logic [6:0] r);
        return ({1'b0, w} == STAGE_WORDS[s] - 8'd1) &&
               ({1'b0, r} == STAGE_REPS[s]  - 8'd1);
    endfunction

endpackage

// File: rtl/twiddle_addr_gen.sv
// Twiddle ROM address sequencer for the radix-4 FFT.
// Walks every stage as nested replay/word loops and presents one ROM address
// per beat on a valid/ready handshake; all outputs come straight from flops.
module twiddle_addr_gen
    import fft_tw_pkg::*;
#(
    parameter int NUM_STAGES = fft_tw_pkg::NUM_STAGES,
    parameter int ADDR_W     = fft_tw_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              valid_o,
    output logic [2:0]        stage_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    tw_state_e   state;
    logic [6:0]  w_cnt;
    logic [6:0]  rep_cnt;
    logic [2:0]  stage_cnt;

    logic        accept;
    logic        w_is_last;
    logic        rep_is_last;
    logic        seq_end;
    logic [6:0]  nxt_w;
    logic [6:0]  nxt_rep;
    logic [2:0]  nxt_stage;
    logic [ADDR_W-1:0] nxt_addr;
    logic        nxt_last;

    assign accept  = valid_o && ready_i;
    assign stage_o = stage_cnt;

    // Work out the beat that follows the current one, wrapping words into
    // replays and replays into stages; seq_end flags the very last beat
    always_comb begin
        w_is_last   = ({1'b0, w_cnt}   == STAGE_WORDS[stage_cnt] - 8'd1);
        rep_is_last = ({1'b0, rep_cnt} == STAGE_REPS[stage_cnt]  - 8'd1);
        nxt_w       = w_cnt + 7'd1;
        nxt_rep     = rep_cnt;
        nxt_stage   = stage_cnt;
        seq_end     = 1'b0;
        if (w_is_last) begin
            nxt_w = '0;
            if (rep_is_last) begin
                nxt_rep = '0;
                if (stage_cnt == 3'(NUM_STAGES - 1)) begin
                    seq_end = 1'b1;
                end else begin
                    nxt_stage = stage_cnt + 3'd1;
                end
            end else begin
                nxt_rep = rep_cnt + 7'd1;
            end
        end
        nxt_addr = ADDR_W'(stage_addr(nxt_stage, nxt_w));
        nxt_last = is_last_beat(nxt_stage, nxt_w, nxt_rep);
    end

    // Control FSM plus loop counters; abort wins over start and handshake,
    // and a beat only advances when the consumer accepts it
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= ST_IDLE;
            w_cnt     <= '0;
            rep_cnt   <= '0;
            stage_cnt <= '0;
            addr_o    <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else if (abort_i) begin
            state     <= ST_IDLE;
            w_cnt     <= '0;
            rep_cnt   <= '0;
            stage_cnt <= '0;
            addr_o    <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state     <= ST_RUN;
                        w_cnt     <= '0;
                        rep_cnt   <= '0;
                        stage_cnt <= '0;
                        addr_o    <= ADDR_W'(stage_addr(3'd0, 7'd0));
                        last_o    <= is_last_beat(3'd0, 7'd0, 7'd0);
                        valid_o   <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (seq_end) begin
                            state     <= ST_DONE;
                            w_cnt     <= '0;
                            rep_cnt   <= '0;
                            stage_cnt <= '0;
                            addr_o    <= '0;
                            last_o    <= 1'b0;
                            valid_o   <= 1'b0;
                            busy_o    <= 1'b0;
                            done_o    <= 1'b1;
                        end else begin
                            w_cnt     <= nxt_w;
                            rep_cnt   <= nxt_rep;
                            stage_cnt <= nxt_stage;
                            addr_o    <= nxt_addr;
                            last_o    <= nxt_last;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/twiddle_addr_gen.md
TWIDDLE_ADDR_GEN -- requirements
Module: twiddle_addr_gen

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 6, number of radix-4 stages (4096-point FFT).
REQ-002 SHALL have parameter ADDR_W, default 11, twiddle ROM address width.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-high reset (1 = reset asserted), despite the name.
REQ-005 SHALL have port start_i, input, 1, one-cycle request to begin an FFT twiddle sequence.
REQ-006 SHALL have port abort_i, input, 1, synchronous flush to IDLE.
REQ-007 SHALL have port ready_i, input, 1, downstream accepts the current address.
REQ-008 SHALL have port addr_o, output, ADDR_W, twiddle ROM word address; drives rom_twiddle addr_i.
REQ-009 SHALL have port valid_o, output, 1, addr_o is meaningful; drives rom_twiddle valid.
REQ-010 SHALL have port stage_o, output, 3, stage index of the current beat.
REQ-011 SHALL have port last_o, output, 1, final beat of the current stage.
REQ-012 SHALL have port busy_o, output, 1, high in RUN.
REQ-013 SHALL have port done_o, output, 1, one-cycle pulse after the final beat of the final stage is accepted.

Function
REQ-014 SHALL implement FSM IDLE -> RUN on start_i; RUN -> DONE on acceptance of last beat of stage NUM_STAGES-1; DONE -> IDLE unconditionally after one cycle.
REQ-015 SHALL ignore start_i in RUN and DONE.
REQ-016 SHALL, per stage s, use constants STAGE_BASE[s] = {0,1,2,4,12,44}, STAGE_WORDS[s] = {1,1,2,8,32,128}, STAGE_REPS[s] = {128,128,64,16,4,1}.
REQ-017 SHALL issue exactly 128 beats per stage: outer loop rep 0..REPS-1, inner loop w 0..WORDS-1, addr_o = STAGE_BASE[s] + w.
REQ-018 SHALL advance to the next beat only when valid_o && ready_i (accept).
REQ-019 SHALL hold addr_o, stage_o, last_o stable while valid_o && !ready_i.
REQ-020 SHALL assert valid_o in the first cycle of RUN with addr_o = 0, stage_o = 0, and keep valid_o high through RUN with no bubbles between beats or stages.
REQ-021 SHALL drive last_o = 1 exactly when w = WORDS-1 and rep = REPS-1.
REQ-022 SHALL, on accepted last beat of stage s < NUM_STAGES-1, present stage s+1, addr STAGE_BASE[s+1] in the next cycle.
REQ-023 SHALL register all outputs (no combinational path from ready_i to any output).
REQ-024 SHALL give abort_i priority over start_i and ready_i: next cycle IDLE, valid_o = 0, done_o not pulsed.
REQ-025 SHALL keep addr_o below 172 at all times (max address 171).

Reset
REQ-026 SHALL, while rst_n = 1, asynchronously force IDLE, addr_o = 0, valid_o = 0, stage_o = 0, last_o = 0, busy_o = 0, done_o = 0, all counters 0.
REQ-027 SHALL, on reset mid-RUN, discard the sequence; a new start_i is required after release.
REQ-028 SHALL sample start_i no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place STAGE_BASE, STAGE_WORDS, STAGE_REPS, NUM_STAGES, ADDR_W and the FSM state enum in shared package fft_tw_pkg, shared with rom_twiddle.
REQ-030 SHALL be a single module with no sub-modules; the w/rep/stage counters are inline.
REQ-031 SHALL require no more than 8-bit rep, 7-bit w and 3-bit stage counters.

Verification
REQ-032 SHALL verify: reset, then start_i pulse with ready_i = 1 -> 768 consecutive valid beats, done_o pulse 769 cycles after start sample; stage 0 gives 128 x addr 0, stage 5 gives addr 44..171 once.
REQ-033 SHALL verify: stage 3 with ready_i = 1 -> addr sequence 4..11 repeated 16 times, last_o only on the 128th beat (addr 11).
REQ-034 SHALL verify: random ready_i (50%) -> addr/stage/last unchanged while stalled, same 768-address sequence as the no-stall run.
REQ-035 SHALL verify: abort_i at beat 300 -> next cycle valid_o = 0, busy_o = 0, no done_o; second start_i restarts at addr 0, stage 0.
REQ-036 SHALL verify: rst_n pulsed mid-stage 2 -> outputs 0 immediately (asynchronously); start_i during RUN -> ignored, sequence unaffected.
